// File: rtl/seg7_temp_decoder.sv
// seg7_temp_decoder
// Watches a two-digit multiplexed 7-segment bus (active-low segments) and
// recovers the displayed temperature. Digits are captured after the digit
// select has been stable long enough, assembled into tens/units frames, and
// a value is published only after MATCH identical valid frames in a row.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_TENS  | waiting for a tens capture; units captures are ignored
// S_UNITS | tens stored, waiting for units; a new tens overwrites it,
//         | and the wait is bounded by TIMEOUT cycles
module seg7_temp_decoder #(
  parameter int SETTLE  = 4,
  parameter int MATCH   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [1:0] dig_sel,
  output logic [7:0] temp_out,
  output logic       temp_valid,
  output logic       frame_err,
  output logic       locked
);

  typedef enum logic {S_TENS = 1'b0, S_UNITS = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_prev_sel;
  logic [3:0]  r_settle_cnt;
  logic [15:0] r_timer;

  logic [3:0]  r_tens;
  logic        r_tens_bad;
  logic [3:0]  r_units;
  logic        r_units_bad;
  logic        r_eval;

  logic [7:0]  r_cand;
  logic [2:0]  r_cnt;
  logic [7:0]  r_temp;
  logic        r_valid;
  logic        r_err;
  logic        r_locked;

  logic [3:0]  w_dig;
  logic        w_bad;
  logic        w_onehot;
  logic        w_stable;
  logic        w_cap;
  logic        w_cap_tens;
  logic        w_cap_units;
  logic        w_timer_hit;
  logic        w_load_tens;
  logic        w_load_units;
  logic        w_timeout_err;
  logic        w_timer_run;
  logic [7:0]  w_value;
  logic [2:0]  w_cnt_next;
  logic        w_publish;

  // Segment pattern to digit; anything outside the ten glyphs is invalid.
  always_comb begin
    w_dig = 4'd0;
    w_bad = 1'b0;
    case (seg_in)
      7'b1000000: w_dig = 4'd0;
      7'b1111001: w_dig = 4'd1;
      7'b0100100: w_dig = 4'd2;
      7'b0110000: w_dig = 4'd3;
      7'b0011001: w_dig = 4'd4;
      7'b0010010: w_dig = 4'd5;
      7'b0000010: w_dig = 4'd6;
      7'b1111000: w_dig = 4'd7;
      7'b0000000: w_dig = 4'd8;
      7'b0010000: w_dig = 4'd9;
      default:    w_bad = 1'b1;
    endcase
  end

  // Capture fires on the edge the settle counter reaches SETTLE; the counter
  // then saturates so a long dwell yields a single capture.
  assign w_onehot    = (dig_sel == 2'b10) || (dig_sel == 2'b01);
  assign w_stable    = w_onehot && (dig_sel == r_prev_sel);
  assign w_cap       = w_stable && (r_settle_cnt == 4'(SETTLE - 1));
  assign w_cap_tens  = w_cap && (dig_sel == 2'b10);
  assign w_cap_units = w_cap && (dig_sel == 2'b01);
  assign w_timer_hit = (r_timer == 16'(TIMEOUT - 1));

  // Track digit-select stability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_sel   <= 2'b00;
      r_settle_cnt <= 4'd0;
    end else begin
      r_prev_sel <= dig_sel;
      if (w_stable) begin
        if (r_settle_cnt != 4'(SETTLE))
          r_settle_cnt <= r_settle_cnt + 4'd1;
      end else begin
        r_settle_cnt <= 4'd0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_TENS;
    else        r_state <= w_next;
  end

  // FSM next-state logic; a capture always beats a timeout on the same edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_TENS:  if (w_cap_tens) w_next = S_UNITS;
      S_UNITS: if (w_cap_units || (w_timer_hit && !w_cap_tens)) w_next = S_TENS;
      default: w_next = S_TENS;
    endcase
  end

  // FSM outputs: datapath load strobes and the timeout error.
  always_comb begin
    w_load_tens   = 1'b0;
    w_load_units  = 1'b0;
    w_timeout_err = 1'b0;
    w_timer_run   = 1'b0;
    case (r_state)
      S_TENS: w_load_tens = w_cap_tens;
      S_UNITS: begin
        w_load_tens   = w_cap_tens;
        w_load_units  = w_cap_units;
        w_timeout_err = w_timer_hit && !w_cap_units && !w_cap_tens;
        w_timer_run   = !w_cap_tens && (w_next == S_UNITS);
      end
      default: ;
    endcase
  end

  // Digit storage, units-wait timer, and the evaluate strobe one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer     <= 16'd0;
      r_tens      <= 4'd0;
      r_tens_bad  <= 1'b0;
      r_units     <= 4'd0;
      r_units_bad <= 1'b0;
      r_eval      <= 1'b0;
    end else begin
      r_timer <= w_timer_run ? r_timer + 16'd1 : 16'd0;
      if (w_load_tens) begin
        r_tens     <= w_dig;
        r_tens_bad <= w_bad;
      end
      if (w_load_units) begin
        r_units     <= w_dig;
        r_units_bad <= w_bad;
      end
      r_eval <= w_load_units;
    end
  end

  // Frame value and the candidate match count it would produce.
  always_comb begin
    w_value = ({4'd0, r_tens} * 8'd10) + {4'd0, r_units};
    if (w_value == r_cand)
      w_cnt_next = (r_cnt == 3'(MATCH)) ? r_cnt : r_cnt + 3'd1;
    else
      w_cnt_next = 3'd1;
    w_publish = (w_cnt_next == 3'(MATCH)) && (!r_locked || (w_value != r_temp));
  end

  // Frame evaluation, publish, and the one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand   <= 8'd0;
      r_cnt    <= 3'd0;
      r_temp   <= 8'd0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= w_timeout_err;
      if (r_eval) begin
        if (r_tens_bad || r_units_bad) begin
          r_err <= 1'b1;
          r_cnt <= 3'd0;
        end else begin
          r_cand <= w_value;
          r_cnt  <= w_cnt_next;
          if (w_publish) begin
            r_temp   <= w_value;
            r_valid  <= 1'b1;
            r_locked <= 1'b1;
          end
        end
      end
    end
  end

  assign temp_out   = r_temp;
  assign temp_valid = r_valid;
  assign frame_err  = r_err;
  assign locked     = r_locked;

endmodule

// File: tb/tb_seg7_temp_decoder.sv
// Testbench for seg7_temp_decoder: directed vector table, hand-written
// timing sequences, and randomized frames against a frame-level model.
module tb_seg7_temp_decoder;

  localparam int SETTLE  = 4;
  localparam int MATCH   = 2;
  localparam int TIMEOUT = 100;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] SEG_TBL [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic [1:0] dig_sel;
  logic [7:0] temp_out;
  logic       temp_valid;
  logic       frame_err;
  logic       locked;

  seg7_temp_decoder #(.SETTLE(SETTLE), .MATCH(MATCH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
    .temp_out(temp_out), .temp_valid(temp_valid), .frame_err(frame_err),
    .locked(locked));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_err   = 0;

  always @(negedge clk) begin
    if (temp_valid) n_valid++;
    if (frame_err)  n_err++;
  end

  // frame-level reference model
  int m_temp, m_locked, m_cand, m_cnt, m_exp_v, m_exp_e;

  typedef struct {
    logic [6:0] tseg;
    logic [6:0] useg;
    int temp;
    int v;
    int e;
    int lk;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dwell(input logic [1:0] sel, input logic [6:0] seg, input int len);
    dig_sel = sel;
    seg_in  = seg;
    repeat (len) tick();
  endtask

  task automatic gap(input int len);
    dig_sel = ($urandom_range(1) == 1) ? 2'b11 : 2'b00;
    seg_in  = BLANK;
    repeat (len) tick();
  endtask

  task automatic frame(input logic [6:0] tseg, input logic [6:0] useg);
    dwell(2'b10, tseg, SETTLE + 3);
    gap(1);
    dwell(2'b01, useg, SETTLE + 3);
    gap(2);
  endtask

  function automatic int m_dec(input logic [6:0] s);
    for (int d = 0; d < 10; d++)
      if (s == SEG_TBL[d]) return d;
    return -1;
  endfunction

  function automatic void m_reset();
    m_temp = 0; m_locked = 0; m_cand = 0; m_cnt = 0;
  endfunction

  function automatic void m_frame(input int t, input int u);
    int val;
    m_exp_v = 0;
    m_exp_e = 0;
    if (t < 0 || u < 0) begin
      m_exp_e = 1;
      m_cnt   = 0;
    end else begin
      val = t * 10 + u;
      if (val == m_cand) begin
        if (m_cnt < MATCH) m_cnt++;
      end else begin
        m_cand = val;
        m_cnt  = 1;
      end
      if (m_cnt == MATCH && (m_locked == 0 || val != m_temp)) begin
        m_temp   = val;
        m_locked = 1;
        m_exp_v  = 1;
      end
    end
  endfunction

  function automatic logic [6:0] rand_bad();
    logic [6:0] s;
    s = 7'($urandom_range(127));
    while (m_dec(s) >= 0) s = 7'($urandom_range(127));
    return s;
  endfunction

  task automatic run_vec(input int i);
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    frame(vecs[i].tseg, vecs[i].useg);
    m_frame(m_dec(vecs[i].tseg), m_dec(vecs[i].useg));
    chk($sformatf("vec%0d temp_out", i), int'(temp_out), vecs[i].temp);
    chk($sformatf("vec%0d temp_valid pulses", i), n_valid - v0, vecs[i].v);
    chk($sformatf("vec%0d frame_err pulses", i), n_err - e0, vecs[i].e);
    chk($sformatf("vec%0d locked", i), int'(locked), vecs[i].lk);
  endtask

  initial begin
    int v0, e0, first;
    vecs[0] = '{SEG_TBL[3], SEG_TBL[8], 0,  0, 0, 0};
    vecs[1] = '{SEG_TBL[3], SEG_TBL[8], 38, 1, 0, 1};
    vecs[2] = '{SEG_TBL[3], SEG_TBL[8], 38, 0, 0, 1};
    vecs[3] = '{BLANK,      SEG_TBL[8], 38, 0, 1, 1};
    vecs[4] = '{SEG_TBL[3], SEG_TBL[8], 38, 0, 0, 1};
    vecs[5] = '{SEG_TBL[3], SEG_TBL[8], 38, 0, 0, 1};
    vecs[6] = '{SEG_TBL[9], SEG_TBL[9], 38, 0, 0, 1};
    vecs[7] = '{SEG_TBL[9], SEG_TBL[9], 99, 1, 0, 1};
    vecs[8] = '{SEG_TBL[0], SEG_TBL[0], 0,  0, 0, 0};
    vecs[9] = '{SEG_TBL[0], SEG_TBL[0], 0,  1, 0, 1};

    rst_n = 1'b0; dig_sel = 2'b00; seg_in = BLANK;
    m_reset();
    repeat (3) tick();
    chk("reset temp_out", int'(temp_out), 0);
    chk("reset temp_valid", int'(temp_valid), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset locked", int'(locked), 0);
    rst_n = 1'b1;
    gap(2);

    for (int i = 0; i < 8; i++) run_vec(i);

    // short units dwell after a tens capture, then timeout back to S_TENS
    first = 0;
    for (int n = 1; n <= SETTLE + TIMEOUT + 20; n++) begin
      if (n <= SETTLE + 3)      begin dig_sel = 2'b10; seg_in = SEG_TBL[4]; end
      else if (n == SETTLE + 4) begin dig_sel = 2'b00; seg_in = BLANK; end
      else if (n <= SETTLE + 7) begin dig_sel = 2'b01; seg_in = SEG_TBL[5]; end
      else                      begin dig_sel = 2'b00; seg_in = BLANK; end
      tick();
      if (frame_err && first == 0) first = n;
    end
    chk("timeout edge", first, SETTLE + 1 + TIMEOUT);
    chk("timeout temp_out held", int'(temp_out), 99);
    e0 = n_err;
    dwell(2'b01, BLANK, SETTLE + 3);
    gap(2);
    chk("units in S_TENS after timeout ignored", n_err - e0, 0);

    // units ignored in S_TENS, tens overwrite in S_UNITS, and publish latency
    v0 = n_valid; e0 = n_err;
    dwell(2'b01, SEG_TBL[1], SETTLE + 3); gap(1);
    dwell(2'b10, SEG_TBL[5], SETTLE + 3); gap(1);
    dwell(2'b10, SEG_TBL[7], SETTLE + 3); gap(1);
    dwell(2'b01, SEG_TBL[2], SETTLE + 3); gap(2);
    m_frame(7, 2);
    dwell(2'b10, SEG_TBL[7], SETTLE + 3); gap(1);
    first = 0;
    dig_sel = 2'b01; seg_in = SEG_TBL[2];
    for (int n = 1; n <= SETTLE + 4; n++) begin
      tick();
      if (temp_valid && first == 0) first = n;
    end
    gap(2);
    m_frame(7, 2);
    chk("publish latency", first, SETTLE + 2);
    chk("overwrite temp_out", int'(temp_out), 72);
    chk("overwrite valid pulses", n_valid - v0, 1);
    chk("overwrite err pulses", n_err - e0, 0);

    // reset asserted mid units dwell
    dwell(2'b10, SEG_TBL[6], SETTLE + 3); gap(1);
    dwell(2'b01, SEG_TBL[6], 2);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("midreset temp_out", int'(temp_out), 0);
    chk("midreset locked", int'(locked), 0);
    chk("midreset temp_valid", int'(temp_valid), 0);
    chk("midreset frame_err", int'(frame_err), 0);
    dwell(2'b00, BLANK, 2);
    rst_n = 1'b1;
    gap(2);
    for (int i = 8; i < 10; i++) run_vec(i);

    // randomized frames against the model
    begin
      int rt, ru, lt, lu, tn, un, ft, fu;
      logic [6:0] ts, us;
      lt = 4; lu = 2;
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(1) == 1) begin rt = lt; ru = lu; end
        else begin rt = $urandom_range(9); ru = $urandom_range(9); end
        lt = rt; lu = ru;
        ts = ($urandom_range(9) == 0) ? rand_bad() : SEG_TBL[rt];
        us = ($urandom_range(9) == 0) ? rand_bad() : SEG_TBL[ru];
        v0 = n_valid; e0 = n_err;
        if ($urandom_range(2) == 0) begin
          dwell($urandom_range(1) ? 2'b10 : 2'b01, SEG_TBL[$urandom_range(9)],
                $urandom_range(SETTLE - 1, 1));
          gap(1);
        end
        if ($urandom_range(3) == 0) begin
          dwell(2'b10, ($urandom_range(1) == 1) ? rand_bad() : SEG_TBL[$urandom_range(9)],
                $urandom_range(SETTLE + 4, SETTLE + 1));
          gap(1);
        end
        tn = $urandom_range(SETTLE + 6, SETTLE + 1);
        dwell(2'b10, ts, tn);
        gap(1);
        if ($urandom_range(2) == 0) begin
          dwell($urandom_range(1) ? 2'b10 : 2'b01, rand_bad(), $urandom_range(SETTLE - 1, 1));
          gap(1);
        end
        un = $urandom_range(SETTLE + 6, SETTLE + 1);
        dwell(2'b01, us, un);
        gap(2);
        ft = m_dec(ts); fu = m_dec(us);
        m_frame(ft, fu);
        chk($sformatf("rnd%0d temp_out", k), int'(temp_out), m_temp);
        chk($sformatf("rnd%0d locked", k), int'(locked), m_locked);
        chk($sformatf("rnd%0d valid pulses", k), n_valid - v0, m_exp_v);
        chk($sformatf("rnd%0d err pulses", k), n_err - e0, m_exp_e);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
